// File: rtl/des_round_scheduler.sv
// Round sequencer for an iterative DES core: load strobe, per-round enable, round index and key rotate control.
// Optional abort input is compiled in when DES_SCHED_ABORT_EN is defined.
module des_round_scheduler #(
  parameter int ROUND_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_strobe_din,
  input  logic       decrypt_din,
  input  logic       done_ack_din,
`ifdef DES_SCHED_ABORT_EN
  input  logic       abort_din,
`endif
  output logic       busy_dout,
  output logic       load_dout,
  output logic       round_enable_dout,
  output logic [3:0] round_count_dout,
  output logic [1:0] key_shift_dout,
  output logic       key_rotate_right_dout,
  output logic       done_valid_dout
);

  typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} state_t;

  localparam logic [1:0] CYC_LAST = 2'(ROUND_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [1:0] cyc_q, cyc_d;
  logic       dir_q, dir_d;
  logic       abort;

`ifdef DES_SCHED_ABORT_EN
  assign abort = abort_din;
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      round_q <= 4'd0;
      cyc_q   <= 2'd0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      cyc_q   <= cyc_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    round_d           = round_q;
    cyc_d             = cyc_q;
    dir_d             = dir_q;
    load_dout         = 1'b0;
    round_enable_dout = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_strobe_din) begin
          dir_d   = decrypt_din;
          state_d = LOAD;
        end
      end
      LOAD: begin
        round_d = 4'd0;
        cyc_d   = 2'd0;
        if (abort) begin
          state_d = IDLE;
        end else begin
          load_dout = 1'b1;
          state_d   = ROUND;
        end
      end
      ROUND: begin
        // An abort discards the block; counters restart clean for the next one.
        if (abort) begin
          state_d = IDLE;
          round_d = 4'd0;
          cyc_d   = 2'd0;
        end else if (cyc_q == CYC_LAST) begin
          round_enable_dout = 1'b1;
          cyc_d             = 2'd0;
          if (round_q == 4'd15) begin
            state_d = DONE;
            round_d = 4'd0;
          end else begin
            round_d = round_q + 4'd1;
          end
        end else begin
          cyc_d = cyc_q + 2'd1;
        end
      end
      DONE: begin
        if (done_ack_din) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Decrypt walks the key schedule backwards, so its first round applies no rotation.
  always_comb begin
    key_shift_dout = 2'd0;
    if (state_q == ROUND) begin
      case (round_q)
        4'd0:                 key_shift_dout = dir_q ? 2'd0 : 2'd1;
        4'd1, 4'd8, 4'd15:    key_shift_dout = 2'd1;
        default:              key_shift_dout = 2'd2;
      endcase
    end
  end

  assign busy_dout             = (state_q != IDLE);
  assign done_valid_dout       = (state_q == DONE);
  assign round_count_dout      = round_q;
  assign key_rotate_right_dout = dir_q;

endmodule

// File: tb/tb_des_round_scheduler.sv
// Directed bench for des_round_scheduler: two instances (1 and 3 cycles per round) with a completion scoreboard.
module tb_des_round_scheduler;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] start, dec_in, ack;
  logic [1:0] busy, load, en, krr, dv;
  logic [3:0] rc [2];
  logic [1:0] ks [2];
`ifdef DES_SCHED_ABORT_EN
  logic [1:0] abort;
`endif

  int total  = 0;
  int passed = 0;

  typedef struct {
    int dut;
    bit dec;
    int lat;
    int sum;
  } sb_item_t;
  sb_item_t sb [$];

  int enc_tab [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  int dec_tab [16] = '{0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      des_round_scheduler #(.ROUND_CYCLES(gi == 0 ? 1 : 3)) u_dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .start_strobe_din      (start[gi]),
        .decrypt_din           (dec_in[gi]),
        .done_ack_din          (ack[gi]),
`ifdef DES_SCHED_ABORT_EN
        .abort_din             (abort[gi]),
`endif
        .busy_dout             (busy[gi]),
        .load_dout             (load[gi]),
        .round_enable_dout     (en[gi]),
        .round_count_dout      (rc[gi]),
        .key_shift_dout        (ks[gi]),
        .key_rotate_right_dout (krr[gi]),
        .done_valid_dout       (dv[gi])
      );
    end
  endgenerate

  task automatic chk(input string tag, input int obs, input int exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
  endtask

  function automatic int all_outs(input int i);
    return int'({busy[i], load[i], en[i], rc[i], ks[i], krr[i], dv[i]});
  endfunction

  // mode 0: leave in DONE; 1: ack after done; 2: ack held high for the whole block
  task automatic run_block(input int i, input bit d, input int mode);
    int n, edges, loads, ens, sum, rc_err, gap_err, last_en;
    sb_item_t it;
    n = (i == 0) ? 1 : 3;
    dec_in[i] = d;
    start[i]  = 1'b1;
    if (mode == 2) ack[i] = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    start[i] = 1'b0;
    it.dut = i; it.dec = d; it.lat = 2 + 16 * n; it.sum = d ? 27 : 28;
    sb.push_back(it);
    loads = 0; ens = 0; sum = 0; rc_err = 0; gap_err = 0; last_en = 0;
    while (!dv[i] && edges < 300) begin
      if (load[i]) begin
        loads++;
        chk("ks_in_load", int'(ks[i]), 0);
      end else if (int'(rc[i]) != ens) begin
        rc_err++;
      end
      if (en[i]) begin
        if (ens < 16)
          chk($sformatf("ks_r%0d_d%0d_n%0d", ens, d, n), int'(ks[i]), d ? dec_tab[ens] : enc_tab[ens]);
        if (ens > 0 && edges - last_en != n) gap_err++;
        last_en = edges;
        sum += int'(ks[i]);
        ens++;
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    if (sb.size() > 0) it = sb.pop_front();
    $display("block dut=%0d dec=%0d done at edge %0d (expected %0d) loads=%0d rounds=%0d shift_sum=%0d",
             i, d, edges, it.lat, loads, ens, sum);
    chk("done_edge", edges, it.lat);
    chk("load_count", loads, 1);
    chk("round_enables", ens, 16);
    chk("shift_sum", sum, it.sum);
    chk("round_count_track", rc_err, 0);
    chk("enable_spacing", gap_err, 0);
    chk("rotate_right", int'(krr[i]), int'(it.dec));
    chk("done_busy", int'(busy[i]), 1);
    chk("done_ks", int'(ks[i]), 0);
    chk("done_rc", int'(rc[i]), 0);
    if (mode != 0) begin
      ack[i] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ack[i] = 1'b0;
      chk("after_ack_dv", int'(dv[i]), 0);
      chk("after_ack_busy", int'(busy[i]), 0);
    end
  endtask

  initial begin
    int cyc, dv_low, ld_seen;
    reset_n = 1'b0;
    start = '0; dec_in = '0; ack = '0;
`ifdef DES_SCHED_ABORT_EN
    abort = '0;
`endif
    @(negedge clk);
    @(negedge clk);
    chk("reset_outs_n1", all_outs(0), 0);
    chk("reset_outs_n3", all_outs(1), 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", int'(busy[0]), 0);

    run_block(0, 1'b0, 1);
    run_block(0, 1'b1, 1);
    run_block(1, 1'b0, 1);
    run_block(0, 1'b0, 2);

    // Hold DONE without ack while pulsing start
    run_block(0, 1'b1, 0);
    dv_low = 0; ld_seen = 0;
    for (int k = 0; k < 10; k++) begin
      start[0] = k[0];
      @(posedge clk);
      @(negedge clk);
      if (!dv[0]) dv_low++;
      if (load[0]) ld_seen++;
    end
    start[0] = 1'b0;
    chk("hold_dv_low_cycles", dv_low, 0);
    chk("hold_load_cycles", ld_seen, 0);
    ack[0] = 1'b1;
    start[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ack[0] = 1'b0;
    start[0] = 1'b0;
    chk("start_with_ack_dropped", int'(busy[0]), 0);
    run_block(0, 1'b0, 1);

    // Asynchronous reset in the middle of a decrypt block
    dec_in[0] = 1'b1;
    start[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    cyc = 0;
    while (rc[0] != 4'd7 && cyc < 40) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    chk("reached_round7", int'(rc[0]), 7);
    #1 reset_n = 1'b0;
    #1;
    chk("async_reset_outs", all_outs(0), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_block(0, 1'b0, 1);

`ifdef DES_SCHED_ABORT_EN
    start[0] = 1'b1;
    dec_in[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    cyc = 0;
    while (rc[0] != 4'd5 && cyc < 40) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    chk("reached_round5", int'(rc[0]), 5);
    abort[0] = 1'b1;
    #1;
    chk("abort_en_suppressed", int'(en[0]), 0);
    @(posedge clk);
    @(negedge clk);
    abort[0] = 1'b0;
    chk("abort_busy", int'(busy[0]), 0);
    dv_low = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (dv[0]) dv_low++;
    end
    chk("abort_no_done", dv_low, 0);
    run_block(0, 1'b0, 1);
`endif

    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
